id_stage: RTL and testbench

- Decode stage of the 5-stage RV32I core; it is the producer side of the EX stage operand/control interface.
- Takes the IF/ID instruction and holds the 32x32 register file, which is written from WB.
- Generates immediates and control signals and detects load-use hazards.
- Drives a registered ID/EX pipeline register whose outputs feed the EX stage directly.

---
 rtl/id_stage.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: decode stage of the 5-stage RV32I pipeline.
//
// Holds the 32x32 register file (written from WB, combinational reads with
// write-first bypass). Decodes the IF/ID instruction into immediates and
// control signals. Detects load-use hazards against the instruction in ID/EX.
// Drives a registered ID/EX pipeline register that feeds EX directly.
//
// Ports
//   clk, rst           core clock, synchronous active-high reset
//   if_valid/instr/pc  IF/ID instruction
//   flush              redirect from EX; kills the ID instruction
//   wb_we/rd/data      register file write port
//   stall              combinational; freezes PC and IF/ID this cycle
//   ex_*, rs*, rd, imm, alu_*, funct*, control bits   ID/EX register outputs
//   illegal_instr      registered; unsupported opcode
module id_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            ex_valid,
  output logic [31:0]     ex_pc,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic            alu_src,
  output logic [1:0]      alu_op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            op_a_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            branch,
  output logic            jump,
  output logic            illegal_instr
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluBr  = 2'b01;
  localparam logic [1:0] AluReg = 2'b10;
  localparam logic [1:0] AluImm = 2'b11;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_we && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [4:0] instr_rs1, instr_rs2, instr_rd;
  logic [2:0] instr_f3;
  logic [6:0] instr_f7;

  assign opcode    = if_instr[6:0];
  assign instr_rd  = if_instr[11:7];
  assign instr_f3  = if_instr[14:12];
  assign instr_rs1 = if_instr[19:15];
  assign instr_rs2 = if_instr[24:20];
  assign instr_f7  = if_instr[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'b0};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1;
  logic [1:0]  dec_alu_op;
  logic        dec_alu_src, dec_op_a_pc;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
  logic        dec_branch, dec_jump, dec_illegal;
  logic        use_rs1, use_rs2;

  always_comb begin
    dec_imm        = '0;
    dec_rs1        = instr_rs1;
    dec_alu_op     = AluAdd;
    dec_alu_src    = 1'b0;
    dec_op_a_pc    = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_illegal    = 1'b0;
    use_rs1        = 1'b0;
    use_rs2        = 1'b0;

    case (opcode)
      OpReg: begin
        dec_alu_op    = AluReg;
        dec_reg_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OpImm: begin
        dec_imm       = imm_i;
        dec_alu_op    = AluImm;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        use_rs1       = 1'b1;
      end
      OpLoad: begin
        dec_imm        = imm_i;
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
        use_rs1        = 1'b1;
      end
      OpStore: begin
        dec_imm       = imm_s;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OpBranch: begin
        dec_imm    = imm_b;
        dec_alu_op = AluBr;
        dec_branch = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OpJal: begin
        dec_imm       = imm_j;
        dec_jump      = 1'b1;
        dec_reg_write = 1'b1;
        dec_op_a_pc   = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OpJalr: begin
        dec_imm       = imm_i;
        dec_jump      = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        use_rs1       = 1'b1;
      end
      OpLui: begin
        // The rs1 field holds immediate bits; force x0 so operand A reads 0.
        dec_imm       = imm_u;
        dec_rs1       = 5'd0;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OpAuipc: begin
        dec_imm       = imm_u;
        dec_op_a_pc   = 1'b1;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand read with write-first bypass
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rd1_val, rd2_val;

  always_comb begin
    rd1_val = '0;
    if (dec_rs1 != 5'd0) begin
      if (wb_we && (wb_rd == dec_rs1)) begin
        rd1_val = wb_data;
      end else begin
        rd1_val = rf_q[dec_rs1];
      end
    end
  end

  always_comb begin
    rd2_val = '0;
    if (instr_rs2 != 5'd0) begin
      if (wb_we && (wb_rd == instr_rs2)) begin
        rd2_val = wb_data;
      end else begin
        rd2_val = rf_q[instr_rs2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard
  // ---------------------------------------------------------------------------
  logic hazard;

  assign hazard = if_valid && ex_valid && mem_read && (rd != 5'd0) &&
                  ((use_rs1 && (instr_rs1 == rd)) || (use_rs2 && (instr_rs2 == rd)));

  // A redirect discards the dependent instruction, so there is nothing to wait for.
  assign stall = hazard && !flush;

  logic load_en;

  assign load_en = if_valid && !flush && !stall;

  // ---------------------------------------------------------------------------
  // ID/EX register; a bubble clears every field
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || !load_en) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      rs1_data      <= '0;
      rs2_data      <= '0;
      imm           <= '0;
      alu_src       <= 1'b0;
      alu_op        <= 2'b00;
      funct3        <= 3'b000;
      funct7        <= 7'b0000000;
      op_a_pc       <= 1'b0;
      rs1           <= 5'd0;
      rs2           <= 5'd0;
      rd            <= 5'd0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_to_reg    <= 1'b0;
      branch        <= 1'b0;
      jump          <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      ex_valid      <= 1'b1;
      ex_pc         <= if_pc;
      rs1_data      <= rd1_val;
      rs2_data      <= rd2_val;
      imm           <= XLEN'($signed(dec_imm));
      alu_src       <= dec_alu_src;
      alu_op        <= dec_alu_op;
      funct3        <= instr_f3;
      funct7        <= instr_f7;
      op_a_pc       <= dec_op_a_pc;
      rs1           <= dec_rs1;
      rs2           <= instr_rs2;
      rd            <= instr_rd;
      reg_write     <= dec_reg_write;
      mem_read      <= dec_mem_read;
      mem_write     <= dec_mem_write;
      mem_to_reg    <= dec_mem_to_reg;
      branch        <= dec_branch;
      jump          <= dec_jump;
      illegal_instr <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: each driven cycle pushes the expected ID/EX
// contents to a queue, which is popped and compared after the next edge.
module tb_id_stage;

  logic        clk, rst, if_valid, flush, wb_we;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        stall, ex_valid, alu_src, op_a_pc;
  logic [31:0] ex_pc, rs1_data, rs2_data, imm;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, mem_read, mem_write, mem_to_reg, branch, jump, illegal_instr;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .alu_src(alu_src), .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
    .op_a_pc(op_a_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch(branch), .jump(jump), .illegal_instr(illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, branch, jump, illegal, op_a_pc}
  // chk  = {alu, imm, rs1_data, rs2_data, funct7, rs1 addr}
  typedef struct {
    logic        ev;
    logic [31:0] pc, imm, rs1d, rs2d;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [6:0]  f7;
    logic [4:0]  rs1a;
    logic [7:0]  ctrl;
    logic [5:0]  chk;
  } exp_t;

  localparam logic [7:0] CtlR     = 8'b1000_0000;
  localparam logic [7:0] CtlLoad  = 8'b1101_0000;
  localparam logic [7:0] CtlStore = 8'b0010_0000;
  localparam logic [7:0] CtlBr    = 8'b0000_1000;
  localparam logic [7:0] CtlJal   = 8'b1000_0101;
  localparam logic [7:0] CtlAuipc = 8'b1000_0001;
  localparam logic [7:0] CtlIll   = 8'b0000_0010;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] pc;

  function automatic exp_t bubble();
    exp_t e;
    e = '{ev: 1'b0, pc: '0, imm: '0, rs1d: '0, rs2d: '0, alu_op: '0, alu_src: 1'b0,
          f7: '0, rs1a: '0, ctrl: '0, chk: 6'h3F};
    return e;
  endfunction

  function automatic exp_t ins(input logic [31:0] p, input logic [7:0] ctrl,
                               input logic [1:0] aop, input logic asrc,
                               input logic [31:0] im, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [6:0] f7,
                               input logic [4:0] r1a, input logic [5:0] chk);
    exp_t e;
    e = '{ev: 1'b1, pc: p, imm: im, rs1d: r1, rs2d: r2, alu_op: aop, alu_src: asrc,
          f7: f7, rs1a: r1a, ctrl: ctrl, chk: chk};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic stall_chk(input logic expv);
    #1;
    chk("stall", 32'(stall), 32'(expv));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    pc = pc + 32'd4;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("ex_valid", 32'(ex_valid), 32'(e.ev));
      chk("ex_pc", ex_pc, e.pc);
      chk("ctrl", 32'({reg_write, mem_read, mem_write, mem_to_reg, branch, jump,
                       illegal_instr, op_a_pc}), 32'(e.ctrl));
      if (e.chk[5]) chk("alu", 32'({alu_op, alu_src}), 32'({e.alu_op, e.alu_src}));
      if (e.chk[4]) chk("imm", imm, e.imm);
      if (e.chk[3]) chk("rs1_data", rs1_data, e.rs1d);
      if (e.chk[2]) chk("rs2_data", rs2_data, e.rs2d);
      if (e.chk[1]) chk("funct7", 32'(funct7), 32'(e.f7));
      if (e.chk[0]) chk("rs1", 32'(rs1), 32'(e.rs1a));
    end
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we   = we;
    wb_rd   = a;
    wb_data = d;
  endtask

  logic [31:0] add_3_5_6, add_3_0_5, addi, srai, lui1, lui4, lw4, add_5_4_2;
  logic [31:0] sw, beq, jal, auipc;

  initial begin
    add_3_5_6 = {7'b0, 5'd6, 5'd5, 3'b000, 5'd3, 7'h33};
    add_3_0_5 = {7'b0, 5'd5, 5'd0, 3'b000, 5'd3, 7'h33};
    addi      = {12'hFFC, 5'd2, 3'b000, 5'd1, 7'h13};
    srai      = {7'b0100000, 5'd3, 5'd2, 3'b101, 5'd1, 7'h13};
    lui1      = {20'h12345, 5'd1, 7'h37};
    lui4      = {20'h12345, 5'd4, 7'h37};
    lw4       = {12'h000, 5'd1, 3'b010, 5'd4, 7'h03};
    add_5_4_2 = {7'b0, 5'd2, 5'd4, 3'b000, 5'd5, 7'h33};
    sw        = {7'b0, 5'd6, 5'd2, 3'b010, 5'b01000, 7'h23};
    beq       = {1'b1, 6'h3F, 5'd6, 5'd2, 3'b000, 4'hC, 1'b1, 7'h63};
    jal       = {1'b0, 10'b0, 1'b1, 8'b0, 5'd1, 7'h6F};
    auipc     = {20'hFFFFF, 5'd1, 7'h17};

    pc    = 32'h0000_1000;
    flush = 1'b0;
    rst   = 1'b1;
    // Reset must win over a valid instruction and a pending write to x1.
    wb(1'b1, 5'd1, 32'h0000_FFFF);
    drive(1'b1, add_3_5_6);
    sb.push_back(bubble()); tick();
    sb.push_back(bubble()); tick();
    rst = 1'b0;
    wb(1'b0, 5'd0, 32'h0);

    // Every register reads zero after reset.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, {7'b0, 5'(32 - i), 5'(i), 3'b000, 5'd0, 7'h33});
      sb.push_back(ins(pc, CtlR, 2'b10, 1'b0, '0, '0, '0, 7'h00, 5'(i), 6'b101111));
      tick();
    end

    // Preload a few registers while ID is idle.
    drive(1'b0, add_3_5_6);
    wb(1'b1, 5'd2, 32'h11); sb.push_back(bubble()); tick();
    wb(1'b1, 5'd6, 32'h66); sb.push_back(bubble()); tick();
    wb(1'b1, 5'd8, 32'h88); sb.push_back(bubble()); tick();

    // Same-cycle write bypass to x5.
    wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    drive(1'b1, add_3_5_6);
    sb.push_back(ins(pc, CtlR, 2'b10, 1'b0, '0, 32'hDEAD_BEEF, 32'h66, 7'h00, 5'd5,
                     6'b101111));
    tick();
    // Write to x0 is dropped and not bypassed; x5 now comes from the array.
    wb(1'b1, 5'd0, 32'h7);
    drive(1'b1, add_3_0_5);
    sb.push_back(ins(pc, CtlR, 2'b10, 1'b0, '0, 32'h0, 32'hDEAD_BEEF, 7'h00, 5'd0,
                     6'b101111));
    tick();
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, add_3_0_5);
    sb.push_back(ins(pc, CtlR, 2'b10, 1'b0, '0, 32'h0, 32'hDEAD_BEEF, 7'h00, 5'd0,
                     6'b101111));
    tick();

    // Immediate and control decode.
    drive(1'b1, addi);
    sb.push_back(ins(pc, CtlR, 2'b11, 1'b1, 32'hFFFF_FFFC, 32'h11, '0, 7'h7F, 5'd2,
                     6'b111010));
    tick();
    drive(1'b1, srai);
    sb.push_back(ins(pc, CtlR, 2'b11, 1'b1, 32'h0000_0403, 32'h11, '0, 7'h20, 5'd2,
                     6'b111010));
    tick();
    // LUI's rs1 field decodes to x8 (holds 0x88); operand must still be zero.
    drive(1'b1, lui1);
    sb.push_back(ins(pc, CtlR, 2'b00, 1'b1, 32'h1234_5000, 32'h0, '0, 7'h00, 5'd0,
                     6'b111001));
    tick();
    drive(1'b1, sw);
    sb.push_back(ins(pc, CtlStore, 2'b00, 1'b1, 32'h8, 32'h11, 32'h66, 7'h00, 5'd2,
                     6'b111101));
    tick();
    drive(1'b1, beq);
    sb.push_back(ins(pc, CtlBr, 2'b01, 1'b0, 32'hFFFF_FFF8, 32'h11, 32'h66, 7'h00, 5'd2,
                     6'b111101));
    tick();
    drive(1'b1, jal);
    sb.push_back(ins(pc, CtlJal, 2'b00, 1'b1, 32'h800, '0, '0, 7'h00, 5'd0, 6'b110000));
    tick();
    drive(1'b1, auipc);
    sb.push_back(ins(pc, CtlAuipc, 2'b00, 1'b1, 32'hFFFF_F000, '0, '0, 7'h00, 5'd0,
                     6'b110000));
    tick();

    // Load-use: one stall cycle, one bubble, then the consumer issues.
    drive(1'b1, lw4);
    stall_chk(1'b0);
    sb.push_back(ins(pc, CtlLoad, 2'b00, 1'b1, 32'h0, 32'h0, '0, 7'h00, 5'd1, 6'b111001));
    tick();
    drive(1'b1, add_5_4_2);
    stall_chk(1'b1);
    sb.push_back(bubble());
    tick();
    drive(1'b1, add_5_4_2);
    stall_chk(1'b0);
    sb.push_back(ins(pc, CtlR, 2'b10, 1'b0, '0, 32'h0, 32'h11, 7'h00, 5'd4, 6'b101111));
    tick();

    // LUI does not read rs1, so no stall behind the load.
    drive(1'b1, lw4);
    sb.push_back(ins(pc, CtlLoad, 2'b00, 1'b1, 32'h0, 32'h0, '0, 7'h00, 5'd1, 6'b111001));
    tick();
    drive(1'b1, lui4);
    stall_chk(1'b0);
    sb.push_back(ins(pc, CtlR, 2'b00, 1'b1, 32'h1234_5000, 32'h0, '0, 7'h00, 5'd0,
                     6'b111001));
    tick();

    // Flush beats a pending load-use stall.
    drive(1'b1, lw4);
    sb.push_back(ins(pc, CtlLoad, 2'b00, 1'b1, 32'h0, 32'h0, '0, 7'h00, 5'd1, 6'b111001));
    tick();
    drive(1'b1, add_5_4_2);
    flush = 1'b1;
    stall_chk(1'b0);
    sb.push_back(bubble());
    tick();
    flush = 1'b0;

    // Unsupported opcode.
    drive(1'b1, 32'h0000_007F);
    sb.push_back(ins(pc, CtlIll, 2'b00, 1'b0, '0, '0, '0, 7'h00, 5'd0, 6'b000000));
    tick();

    // Reset during a stall clears ID/EX, so the stall is gone next cycle.
    drive(1'b1, lw4);
    sb.push_back(ins(pc, CtlLoad, 2'b00, 1'b1, 32'h0, 32'h0, '0, 7'h00, 5'd1, 6'b111001));
    tick();
    drive(1'b1, add_5_4_2);
    rst = 1'b1;
    stall_chk(1'b1);
    sb.push_back(bubble());
    tick();
    rst = 1'b0;
    drive(1'b1, add_5_4_2);
    stall_chk(1'b0);
    sb.push_back(ins(pc, CtlR, 2'b10, 1'b0, '0, 32'h0, 32'h0, 7'h00, 5'd4, 6'b101111));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
